// File: rtl/eth_10g_pause_rx_ctrl_if.sv
// Pause-quanta stream from the RX pause-length timing adapter into the pause controller.
interface eth_10g_pause_rx_ctrl_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/eth_10g_pause_rx_ctrl.sv
// Receive-side 802.3x pause controller: pause timer and TX hold-off request.
// Optional accepted-pause counter is built only when PAUSE_STATS_EN is defined.
//
// state  | meaning
// IDLE   | no pause in effect, tx_pause low
// PAUSED | timer running, tx_pause high
module eth_10g_pause_rx_ctrl #(
    parameter int QUANTA_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        reset_n,
    eth_10g_pause_rx_ctrl_if.slave      rx,
    input  logic                        pause_en,
    output logic                        tx_pause,
    output logic [15:0]                 pause_remaining,
    output logic                        pause_done,
    output logic [31:0]                 pause_count
);
    localparam int SW = (QUANTA_CYCLES > 1) ? $clog2(QUANTA_CYCLES) : 1;
    localparam logic [SW-1:0] SUB_MAX = SW'(QUANTA_CYCLES - 1);

    typedef enum logic {IDLE, PAUSED} state_t;

    state_t        state, state_nxt;
    logic [15:0]   quanta_cnt, quanta_nxt;
    logic [SW-1:0] sub_cnt, sub_nxt;
    logic          done_nxt;
    logic          ready_q;
    logic          accept;

    assign accept = rx.in_valid && ready_q && pause_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            quanta_cnt <= '0;
            sub_cnt    <= '0;
            pause_done <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state      <= state_nxt;
            quanta_cnt <= quanta_nxt;
            sub_cnt    <= sub_nxt;
            pause_done <= done_nxt;
            ready_q    <= 1'b1;
        end
    end

    // Disable beats accept, and a new frame always overrides the running timer.
    always_comb begin
        state_nxt  = state;
        quanta_nxt = quanta_cnt;
        sub_nxt    = sub_cnt;
        done_nxt   = 1'b0;
        if (!pause_en) begin
            state_nxt  = IDLE;
            quanta_nxt = '0;
            sub_nxt    = '0;
        end else if (accept) begin
            if (rx.in_data != 16'd0) begin
                state_nxt  = PAUSED;
                quanta_nxt = rx.in_data;
                sub_nxt    = SUB_MAX;
            end else begin
                state_nxt  = IDLE;
                quanta_nxt = '0;
                sub_nxt    = '0;
            end
        end else if (state == PAUSED) begin
            if (sub_cnt != '0) begin
                sub_nxt = sub_cnt - 1'b1;
            end else if (quanta_cnt > 16'd1) begin
                quanta_nxt = quanta_cnt - 16'd1;
                sub_nxt    = SUB_MAX;
            end else begin
                quanta_nxt = '0;
                state_nxt  = IDLE;
                done_nxt   = 1'b1;
            end
        end
    end

    assign tx_pause        = (state == PAUSED);
    assign pause_remaining = quanta_cnt;
    assign rx.in_ready     = ready_q;

`ifdef PAUSE_STATS_EN
    logic [31:0] count_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            count_q <= '0;
        else if (accept)
            count_q <= count_q + 32'd1;
    end
    assign pause_count = count_q;
`else
    assign pause_count = 32'd0;
`endif
endmodule

// File: doc/eth_10g_pause_rx_ctrl.md
# eth_10g_pause_rx_ctrl

Receive-side 802.3x pause controller for the 10G MAC. It sinks the 16-bit pause-quanta stream from the RX pause-length timing adapter and runs the pause timer. It drives the transmit hold-off request that stops the TX datapath from starting new frames. It also exposes remaining-quanta status, an expiry pulse and an optional accepted-pause counter.

## Interface
- QUANTA_CYCLES, 8: clock cycles per pause quantum (512 bit times at 64 bits/cycle); legal range 2..256.
- clk  in  1  MAC clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  pause-quanta word valid; upstream cannot be backpressured.
- in_data  in  16  pause quanta from the received pause frame.
- in_ready  out  1  sink ready; 0 in reset, 1 otherwise.
- pause_en  in  1  pause response enable (CSR); 0 ignores frames and cancels an active pause.
- tx_pause  out  1  hold-off request to TX: no new frame may start while high.
- pause_remaining  out  16  quanta left, including the quantum in progress.
- pause_done  out  1  one-cycle pulse on natural timer expiry.
- pause_count  out  32  accepted pause words; present only with PAUSE_STATS_EN.

## Operation
- FSM states:
  - IDLE: tx_pause=0.
  - PAUSED: tx_pause=1.
- Accept: in_valid && in_ready && pause_en.
- Accept with in_data=Q>0:
  - Load quanta_cnt=Q and sub_cnt=QUANTA_CYCLES-1.
  - Enter PAUSED from either state. A new frame always reloads; 802.3x override, never additive.
- Accept with Q=0:
  - In PAUSED, go to IDLE, quanta_cnt=0, no pause_done.
  - In IDLE, no state change.
- PAUSED, no accept, each cycle:
  - sub_cnt≠0: sub_cnt--.
  - sub_cnt=0 and quanta_cnt>1: quanta_cnt--, sub_cnt=QUANTA_CYCLES-1.
  - sub_cnt=0 and quanta_cnt=1: quanta_cnt=0, go to IDLE, pulse pause_done.
- pause_en=0:
  - in_valid is discarded and in_ready stays 1.
  - If PAUSED, go to IDLE next edge and clear the counters, no pause_done.
- pause_remaining = quanta_cnt, registered.
- Counter widths: quanta_cnt 16 bits, sub_cnt ceil(log2(QUANTA_CYCLES)) bits. No arithmetic overflow is possible. Q=0xFFFF is legal.

## Timing
- Reset values: tx_pause=0, pause_remaining=0, pause_done=0, in_ready=0, pause_count=0. Internal state is IDLE with counters 0.
- Reset asserted mid-pause drops tx_pause immediately (asynchronous) and discards the timer.
- Accept at edge N gives tx_pause=1 and pause_remaining=Q from N+1 (latency 1).
- Q>0 with no further events keeps tx_pause high for exactly Q×QUANTA_CYCLES cycles.
- pause_done is high in the first cycle tx_pause is low after expiry.
- Accept on the same edge as expiry: the reload wins, there is no pause_done, and tx_pause stays continuous.
- pause_en falling and accept on the same edge: pause_en wins, the frame is discarded and the block goes to IDLE.
- Every output is registered; there are no combinational paths from inputs.

## Configuration
- PAUSE_STATS_EN defined:
  - pause_count increments on every accept, including Q=0, and wraps 0xFFFFFFFF→0.
  - Frames discarded while pause_en=0 are not counted.
- PAUSE_STATS_EN undefined: pause_count is tied to 0 and no counter logic is generated.

## Test plan
- QUANTA_CYCLES=8, pause_en=1, one word Q=3 → tx_pause high exactly 24 cycles from N+1. pause_remaining reads 3,2,1 (8 cycles each). pause_done pulses once.
- Q=100 accepted, then Q=2 accepted 50 cycles later → pause_remaining=2 next cycle. tx_pause falls 16 cycles after the second accept.
- Q=10 accepted, then Q=0 accepted 5 cycles later → tx_pause=0 on the next cycle with no pause_done. With PAUSE_STATS_EN, pause_count=2.
- Q=1 accepted, second Q=5 presented on the expiry edge (cycle 8) → tx_pause stays continuous for 8+40 cycles with no pause_done at cycle 8.
- pause_en=0 with Q=7 → tx_pause stays 0 and pause_count is unchanged. Separately, drop pause_en mid-pause → tx_pause=0 next cycle.
- reset_n low 3 cycles into Q=4 → all outputs 0 immediately. After release in_ready=1 and the block is IDLE.
